// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Payload is zero-extended by the caller; zero bits leave the XOR unchanged.
  function automatic logic parity_bit(input logic [63:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick_out on the wrap.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit counter, held at zero while cleared so each period starts fresh.
  always_ff @(posedge clk) begin
    if (rst || clear_in) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick_out = !clear_in && (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a byte FIFO: pop, load, then send start/data/parity/stop.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_r;
  logic [IW-1:0]         bit_idx;
  logic                  tick;
  logic                  baud_clr;

  // Only the line-driving states run the baud timer; LOAD clears it so START gets a full period.
  assign baud_clr = !(state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_in (baud_clr),
    .tick_out (tick)
  );

  // Read strobe and busy are pure state decodes, so no input reaches them combinationally.
  assign fifo_read_en_out = (state == ST_FETCH);
  assign busy_out         = (state != ST_IDLE);

  // Frame sequencer; tx_out is registered from the current state, so every level is one cycle late but exactly one period long.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_out  <= 1'b1;
      shift   <= '0;
      par_r   <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_out <= 1'b1;
          if (!fifo_empty_in) state <= ST_FETCH;
        end
        ST_FETCH: begin
          tx_out <= 1'b1;
          state  <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_out  <= 1'b1;
          shift   <= fifo_data_in;
          par_r   <= parity_bit(64'(fifo_data_in), PARITY);
          bit_idx <= '0;
          state   <= ST_START;
        end
        ST_START: begin
          tx_out <= 1'b0;
          if (tick) begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx_out <= shift[0];
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          tx_out <= par_r;
          if (tick) begin
            bit_idx <= '0;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_out <= 1'b1;
          if (tick) begin
            if (bit_idx == LAST_STOP) state <= ST_IDLE;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        default: begin
          tx_out <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Serial transmitter that sits directly downstream of the read port of the design's byte FIFO.
- Pops one byte at a time whenever the FIFO reports non-empty and serialises it as an 8N1-style UART frame on tx_out, LSB first.
- Parity and stop-bit count are set by parameters.
- Runs in the FIFO's read-clock domain.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of each serial payload.
- CLKS_PER_BIT, 434, clk cycles per serial bit; 50 MHz / 115200 baud. Legal range ≥ 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk, input, 1, single clock; the FIFO's read_clk.
- rst, input, 1, reset; synchronous, active-high.
- fifo_data_in, input, DATA_WIDTH, FIFO data_out. It is registered in the FIFO and valid the cycle after a read strobe.
- fifo_empty_in, input, 1, FIFO empty flag.
- fifo_read_en_out, output, 1, FIFO read strobe.
- tx_out, output, 1, serial line; idles high.
- busy_out, output, 1, high from FETCH through the last stop bit.

Behaviour:
- Reset, sampled on the clk edge while rst = 1:
  - state = IDLE, tx_out = 1, busy_out = 0, fifo_read_en_out = 0.
  - Baud counter and bit index are cleared.
  - rst dominates every other input.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out = 1.
  - If fifo_empty_in = 0, go to FETCH; otherwise stay.
- FETCH:
  - fifo_read_en_out = 1 for exactly this one cycle. It is decoded from the state register, with no combinational path from inputs.
  - Next state is LOAD.
- LOAD:
  - Capture fifo_data_in into the shift register.
  - Compute the parity bit as the XOR of the payload, inverted for odd parity.
  - Clear the baud counter and go to START.
- START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA:
  - tx_out = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After DATA_WIDTH bits, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: tx_out = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_out = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Latency: fifo_empty_in falls while in IDLE at edge N; read_en is high during cycle N+1; data is captured at N+2; tx_out falls at edge N+3.
  - Inter-frame gap: tx_out stays high for 3 extra cycles (IDLE, FETCH, LOAD) between back-to-back frames. No gap compression is required.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0 to CLKS_PER_BIT−1, wraps to 0, and emits a one-cycle tick on the wrap.
  - Every bit period is exactly CLKS_PER_BIT cycles.
- Outputs:
  - tx_out is registered, so there are no glitches.
  - busy_out = (state != IDLE).
- Boundary conditions:
  - fifo_empty_in is ignored outside IDLE, so at most one read is issued per frame.
  - The FIFO itself blocks reads when empty, so no underflow guard is needed in FETCH.
  - Reset mid-frame: tx_out returns to 1 on the next edge. A byte already popped is discarded and not retransmitted.
  - A FIFO that stays non-empty produces continuous frames with no lost or duplicated bytes.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_t.
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants.
  - Helper function parity_bit(data, mode).
- Sub-module uart_baud_gen, parameter CLKS_PER_BIT:
  - Ports: clk, rst, clear_in, tick_out.
  - Shared later with the receiver.

Test Plan:
All scenarios use CLKS_PER_BIT = 4, STOP_BITS = 1, PARITY = 0 unless stated.
- Reset: assert rst 3 cycles with FIFO non-empty -> tx_out = 1, busy_out = 0, fifo_read_en_out = 0 throughout; no read issued.
- Single byte:
  - Stimulus: write 0xA5 into the FIFO.
  - Read strobe: exactly one high cycle.
  - Line sequence, 4 cycles each: 0, then 1,0,1,0,0,1,0,1, then 1 (40 cycles total).
  - tx_out falls 3 cycles after empty deasserts; the FIFO returns to empty.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> three frames, bytes in order, each separated by exactly 3 extra idle-high cycles; 3 read strobes total.
- Parity: PARITY = 1 with 0xA5 -> parity bit 0; PARITY = 2 -> parity bit 1; PARITY = 1 with 0x07 -> parity bit 1. Frame length is 44 cycles.
- Two stop bits: STOP_BITS = 2 with 0x81 -> stop high for 8 cycles before the next start bit.
- Mid-frame reset: assert rst during DATA bit 3 of 0x55 -> tx_out = 1 on the next edge and state = IDLE. The next FIFO byte, 0x12, is sent intact and 0x55 is never resent.
